// File: rtl/imm_extend_stage_if.sv
// Fetch-side and ALU-side handshake bundle for the immediate extend stage.
interface imm_extend_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_opcode;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_rd;
  logic              out_extend;
  logic [DATA_W-1:0] out_imm;
  logic [7:0]        out_drop_cnt;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
           out_extend, out_imm, out_drop_cnt
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
           out_extend, out_imm, out_drop_cnt
  );
endinterface

// File: rtl/imm_extend_stage.sv
// Decode/extend stage: splits the instruction and sign/zero-extends its immediate.
// One-cycle latency; 2-entry skid (OUT + SKID) keeps in_ready a pure register.
module imm_extend_stage #(
  parameter int          DATA_W    = 32,
  parameter int          IMM_W     = 16,
  parameter logic [15:0] SIGN_MASK = 16'h028C
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_extend_stage_if.slave bus
);

  typedef struct packed {
    logic [3:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic              extend;
    logic [DATA_W-1:0] imm;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t r_state;
  state_t w_state_nxt;
  entry_t r_out;
  entry_t r_skid;
  entry_t w_new;
  logic   r_in_rdy;
  logic [7:0] r_drop_cnt;

  logic       w_in_xfer;
  logic       w_out_xfer;
  logic       w_ld_out_new;
  logic       w_ld_out_skid;
  logic       w_ld_skid;
  logic [1:0] w_drop_n;
  logic [8:0] w_drop_sum;
  logic       w_extend;
  logic       w_unused_bits;

  assign w_in_xfer  = bus.in_valid & r_in_rdy;
  assign w_out_xfer = (r_state != S_EMPTY) & bus.out_ready;

  assign w_extend = SIGN_MASK[bus.in_instr[DATA_W-1 -: 4]];
  assign w_unused_bits = ^bus.in_instr[27:26];

  always_comb begin
    w_new        = '0;
    w_new.opcode = bus.in_instr[DATA_W-1 -: 4];
    w_new.rs     = bus.in_instr[25:21];
    w_new.rt     = bus.in_instr[20:16];
    w_new.rd     = bus.in_instr[15:11];
    w_new.extend = w_extend;
    w_new.imm    = {{(DATA_W-IMM_W){w_extend & bus.in_instr[IMM_W-1]}},
                    bus.in_instr[IMM_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_in_xfer) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_in_xfer && !w_out_xfer)      w_state_nxt = S_FULL;
          else if (!w_in_xfer && w_out_xfer) w_state_nxt = S_EMPTY;
        end
        S_FULL:  if (w_out_xfer) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // An entry leaving downstream in the flush cycle is delivered, not dropped.
  always_comb begin
    w_ld_out_new  = 1'b0;
    w_ld_out_skid = 1'b0;
    w_ld_skid     = 1'b0;
    w_drop_n      = 2'd0;
    if (bus.flush) begin
      case (r_state)
        S_ONE:   w_drop_n = w_out_xfer ? 2'd0 : 2'd1;
        S_FULL:  w_drop_n = w_out_xfer ? 2'd1 : 2'd2;
        default: w_drop_n = 2'd0;
      endcase
    end else begin
      case (r_state)
        S_EMPTY: w_ld_out_new = w_in_xfer;
        S_ONE: begin
          w_ld_out_new = w_in_xfer & w_out_xfer;
          w_ld_skid    = w_in_xfer & ~w_out_xfer;
        end
        S_FULL:  w_ld_out_skid = w_out_xfer;
        default: w_ld_out_new = 1'b0;
      endcase
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drop_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_in_rdy   <= 1'b1;
      r_drop_cnt <= 8'd0;
    end else begin
      if (w_ld_out_new)       r_out <= w_new;
      else if (w_ld_out_skid) r_out <= r_skid;
      if (w_ld_skid)          r_skid <= w_new;
      r_in_rdy   <= (w_state_nxt != S_FULL);
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign bus.in_ready     = r_in_rdy;
  assign bus.out_valid    = (r_state != S_EMPTY);
  assign bus.out_opcode   = r_out.opcode;
  assign bus.out_rs       = r_out.rs;
  assign bus.out_rt       = r_out.rt;
  assign bus.out_rd       = r_out.rd;
  assign bus.out_extend   = r_out.extend;
  assign bus.out_imm      = r_out.imm;
  assign bus.out_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: directed cases plus randomized traffic against a queue model.
module tb_imm_extend_stage;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_extend_stage_if #(.DATA_W(32)) bus ();

  imm_extend_stage dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [51:0] q[$];
  int          m_drop = 0;
  bit          m_inx;
  bit          m_outx;
  logic [51:0] dut_entry;
  logic [15:0] smask;

  assign dut_entry = {bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_rd,
                      bus.out_extend, bus.out_imm};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected decode straight from the opcode table: ADD, SUB, SLT, AND/MOVE2 sign-extend.
  function automatic logic [51:0] mdl(input logic [31:0] ins);
    logic        ext;
    logic [31:0] v;
    ext = ins[31:28] inside {4'd2, 4'd3, 4'd7, 4'd9};
    if (ext) v = 32'($signed(ins[15:0]));
    else     v = 32'(ins[15:0]);
    return {ins[31:28], ins[25:21], ins[20:16], ins[15:11], ext, v};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_drop = 0;
    end else begin
      m_inx  = bus.in_valid && (q.size() < 2);
      m_outx = bus.out_ready && (q.size() > 0);
      if (bus.flush) begin
        m_drop = m_drop + q.size() - int'(m_outx);
        if (m_drop > 255) m_drop = 255;
        q.delete();
      end else begin
        if (m_outx) void'(q.pop_front());
        if (m_inx)  q.push_back(mdl(bus.in_instr));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      check("drop_cnt", 64'(bus.out_drop_cnt), 64'(m_drop));
      if (q.size() != 0) check("entry", 64'(dut_entry), 64'(q[0]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] ins);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    smask         = 16'h028C;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_imm", 64'(bus.out_imm), 64'd0);
    check("rst_drop", 64'(bus.out_drop_cnt), 64'd0);
    rst_n = 1'b1;
    cyc();

    send1(32'h2000_FFFE);
    check("sign_valid", 64'(bus.out_valid), 64'd1);
    check("sign_opcode", 64'(bus.out_opcode), 64'd2);
    check("sign_extend", 64'(bus.out_extend), 64'd1);
    check("sign_imm", 64'(bus.out_imm), 64'hFFFF_FFFE);
    send1(32'h4000_8001);
    check("zero_extend", 64'(bus.out_extend), 64'd0);
    check("zero_imm", 64'(bus.out_imm), 64'h0000_8001);
    send1(32'h9000_8001);
    check("op9_extend", 64'(bus.out_extend), 64'd1);
    check("op9_imm", 64'(bus.out_imm), 64'hFFFF_8001);

    for (int op = 0; op < 16; op++) begin
      send1({op[3:0], 12'h000, 16'h8000});
      check("sweep_extend", 64'(bus.out_extend), 64'(smask[op]));
    end
    cyc();

    // Backpressure: A, B fill the stage, C waits at the source.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h3000_8111;
    cyc();
    bus.in_instr  = 32'h5000_8222;
    cyc();
    check("bp_full_rdy", 64'(bus.in_ready), 64'd0);
    check("bp_out_a", 64'(bus.out_imm), 64'hFFFF_8111);
    bus.in_instr  = 32'h7123_0333;
    cyc();
    check("bp_hold_rdy", 64'(bus.in_ready), 64'd0);
    check("bp_hold_a", 64'(bus.out_imm), 64'hFFFF_8111);
    bus.out_ready = 1'b1;
    cyc();
    check("bp_out_b_vld", 64'(bus.out_valid), 64'd1);
    check("bp_out_b", 64'(bus.out_imm), 64'h0000_8222);
    check("bp_rdy_back", 64'(bus.in_ready), 64'd1);
    cyc();
    bus.in_valid = 1'b0;
    check("bp_out_c_vld", 64'(bus.out_valid), 64'd1);
    check("bp_out_c", 64'(bus.out_imm), 64'h0000_0333);
    cyc();
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = $urandom;
      check("stream_rdy", 64'(bus.in_ready), 64'd1);
      cyc();
      check("stream_vld", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    cyc();

    for (int it = 0; it < 130; it++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_instr  = $urandom;
      cyc();
      bus.in_instr  = $urandom;
      cyc();
      bus.in_instr  = $urandom;
      bus.flush     = 1'b1;
      cyc();
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      if (it == 0) begin
        check("flush_vld", 64'(bus.out_valid), 64'd0);
        check("flush_drop2", 64'(bus.out_drop_cnt), 64'd2);
      end
    end
    check("flush_sat", 64'(bus.out_drop_cnt), 64'd255);

    // Reset lands between edges while the stage is full.
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h3000_1234;
    cyc();
    bus.in_instr = 32'h3000_5678;
    cyc();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vld", 64'(bus.out_valid), 64'd0);
    check("arst_rdy", 64'(bus.in_ready), 64'd1);
    check("arst_drop", 64'(bus.out_drop_cnt), 64'd0);
    check("arst_imm", 64'(bus.out_imm), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_rst_rdy", 64'(bus.in_ready), 64'd1);
    check("post_rst_vld", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    send1(32'h2000_FFFE);
    check("post_rst_imm", 64'(bus.out_imm), 64'hFFFF_FFFE);
    cyc();

    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 31) == 0);
      bus.in_instr  = $urandom;
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_extend_stage.md
Name: imm_extend_stage

Overview:
- Registered decode/extend stage between instruction fetch and the ALU operand mux.
- Splits each incoming 32-bit instruction into fields and selects sign- or zero-extension of the 16-bit immediate from the 4-bit opcode.
- Emits the 32-bit extended immediate plus the Extend flag.
- valid/ready handshake on both sides; 2-entry skid buffer so in_ready is a pure register output.

Parameters:
- DATA_W, 32, instruction and extended-immediate width.
- IMM_W, 16, immediate field width, instr[IMM_W-1:0].
- SIGN_MASK, 16'h028C, bit k set means opcode k sign-extends. Default set is opcodes 2, 3, 7, 9 (ADD, SUB, SLT, AND/MOVE2); all others zero-extend.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept; registered
- in_instr  in  DATA_W  instruction word
- flush  in  1  synchronous pipeline flush (branch/jump taken)
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_opcode  out  4  instr[31:28]
- out_rs  out  5  instr[25:21]
- out_rt  out  5  instr[20:16]
- out_rd  out  5  instr[15:11]
- out_extend  out  1  1 = sign-extended, 0 = zero-extended
- out_imm  out  DATA_W  extended immediate
- out_drop_cnt  out  8  saturating count of valid entries discarded by flush

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, in_ready=1, all data outputs 0, skid empty, out_drop_cnt=0. Must hold regardless of any in-flight transfer.
- Handshakes:
  - Input transfer when in_valid & in_ready at a rising edge.
  - Output transfer when out_valid & out_ready.
  - Data outputs stay stable while out_valid & ~out_ready.
- Extend computation on capture:
  - extend = SIGN_MASK[opcode].
  - imm = extend ? {{(DATA_W-IMM_W){instr[15]}}, instr[15:0]} : {{(DATA_W-IMM_W){1'b0}}, instr[15:0]}.
  - Fields are computed at input capture and stored per entry (opcode, rs, rt, rd, extend, imm).
- Latency: an accepted instruction appears on the outputs the next cycle when the output register is empty or draining.
- Occupancy states (2 registers: OUT, SKID):
  - EMPTY: out_valid=0.
    - Input transfer loads OUT → ONE.
  - ONE: OUT valid, SKID empty.
    - Input and output transfer in the same cycle: OUT reloads, stay ONE.
    - Input transfer only: load SKID → FULL.
    - Output transfer only → EMPTY.
  - FULL: OUT and SKID valid; in_ready=0 (registered, asserted the cycle after entering FULL).
    - Output transfer: SKID moves to OUT → ONE, in_ready=1 next cycle.
- Ordering: strictly FIFO; no entry dropped or duplicated except on flush.
- in_ready=0 only in FULL.
- flush (priority over all handshakes):
  - Next state is EMPTY; any input offered that cycle is discarded.
  - out_drop_cnt += number of valid entries cleared (0, 1 or 2), saturating at 255.
  - An output transfer in the flush cycle still completes downstream and is not counted.
- Data registers may hold stale values when out_valid=0; the bench must not check them then.

Test Plan:
- Sign path: in_instr=32'h2000_FFFE with out_ready=1 → next cycle out_valid=1, out_opcode=2, out_extend=1, out_imm=32'hFFFF_FFFE.
- Zero path: 32'h4000_8001 (opcode 4) → out_extend=0, out_imm=32'h0000_8001. 32'h9000_8001 → out_extend=1, out_imm=32'hFFFF_8001. Sweep all 16 opcodes with imm=16'h8000 and check out_extend equals SIGN_MASK bit.
- Backpressure: out_ready=0, offer A, B, C back-to-back →
  - A in OUT, B in SKID.
  - in_ready=0 from cycle 3; C held by source.
  - Raise out_ready → outputs A, B, C in order with no gaps after release.
- Streaming: out_ready=1, 10 consecutive instructions → 10 outputs on consecutive cycles; in_ready constantly 1.
- Flush: FULL with A, B; pulse flush while offering C → next cycle out_valid=0, C not delivered, out_drop_cnt=2. Repeat 130 times → out_drop_cnt saturates at 255.
- Reset mid-operation: FULL state, assert rst_n=0 between clock edges → outputs clear immediately; after release in_ready=1, out_valid=0, out_drop_cnt=0, and first new instruction passes normally.
